// File: rtl/branch_predict_ctrl_pkg.sv
// Shared encodings for the branch predictor / next-PC controller.
package branch_predict_ctrl_pkg;

   // Next-PC mux select encodings
   localparam logic [1:0] SEL_SEQ     = 2'd0;  // pc + 1
   localparam logic [1:0] SEL_TGT     = 2'd1;  // jump / predicted branch target
   localparam logic [1:0] SEL_JR      = 2'd2;  // register-file jump address
   localparam logic [1:0] SEL_RECOVER = 2'd3;  // mispredict recovery address

   // Weakly not-taken is the power-up state of every table entry
   localparam logic [1:0] CNT_RESET = 2'b01;

   // Controller state: RECOVER covers the one wrong-path fetch after a redirect
   typedef enum logic [0:0] {
      ST_NORMAL  = 1'b0,
      ST_RECOVER = 1'b1
   } state_t;

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// 2-bit saturating up/down counter next-value logic (one per table entry).
module sat_counter2 (
   input  logic [1:0] cnt_i,
   input  logic       en_i,
   input  logic       up_i,
   output logic [1:0] cnt_o
);

   // Step toward 11 on taken, toward 00 on not-taken, holding at the rails
   always_comb begin
      cnt_o = cnt_i;
      if (en_i) begin
         if (up_i) begin
            if (cnt_i != 2'b11) begin
               cnt_o = cnt_i + 2'b01;
            end else begin
               cnt_o = cnt_i;
            end
         end else begin
            if (cnt_i != 2'b00) begin
               cnt_o = cnt_i - 2'b01;
            end else begin
               cnt_o = cnt_i;
            end
         end
      end else begin
         cnt_o = cnt_i;
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction table, next-PC source arbitration and evaluation counters.
module branch_predict_ctrl
   import branch_predict_ctrl_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      if_pc,
   input  logic             if_is_branch,
   input  logic             if_is_jump,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic [31:0]      ex_pc,
   input  logic             ex_taken,
   input  logic             ex_predicted,
   input  logic             ex_jr,
   input  logic             stall,
   output logic             predict_taken,
   output logic [1:0]       pc_sel,
   output logic [31:0]      recover_pc,
   output logic             pc_write,
   output logic             if_flush,
   output logic             id_flush,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << IDX_W;

   state_t           state_q, state_d;
   logic [1:0]       table_q [ENTRIES];
   logic [1:0]       table_d [ENTRIES];
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] if_idx_s;
   logic [IDX_W-1:0] ex_idx_s;
   logic             resolve_s;
   logic             mispredict_s;
   logic             jr_s;
   logic             predict_s;
   logic             unused_pc_bits_s;

   assign if_idx_s     = if_pc[IDX_W-1:0];
   assign ex_idx_s     = ex_pc[IDX_W-1:0];
   assign resolve_s    = ex_valid & ex_is_branch;
   assign mispredict_s = resolve_s & (ex_taken != ex_predicted);
   assign jr_s         = ex_valid & ex_jr;

   // Only the low PC bits index the table
   assign unused_pc_bits_s = ^if_pc[31:IDX_W];

   // Table read happens on the registered value, so a same-index update
   // in this cycle is only visible to the next prediction
   assign predict_s     = if_is_branch & table_q[if_idx_s][1] & (state_q == ST_NORMAL);
   assign predict_taken = predict_s;

   // Per-entry saturating counter next values
   for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
      sat_counter2 u_cnt (
         .cnt_i (table_q[g]),
         .en_i  (resolve_s && (ex_idx_s == IDX_W'(g))),
         .up_i  (ex_taken),
         .cnt_o (table_d[g])
      );
   end

   // Next-PC arbitration, flush generation and FSM next state
   always_comb begin
      pc_sel     = SEL_SEQ;
      pc_write   = 1'b1;
      if_flush   = (state_q == ST_RECOVER);
      id_flush   = 1'b0;
      recover_pc = 32'h0000_0000;
      state_d    = ST_NORMAL;
      if (mispredict_s) begin
         pc_sel   = SEL_RECOVER;
         if_flush = 1'b1;
         id_flush = 1'b1;
         state_d  = ST_RECOVER;
         // Taken target arrives on the mux from the EX path, not from here
         if (!ex_taken) begin
            recover_pc = ex_pc + 32'd1;
         end else begin
            recover_pc = 32'h0000_0000;
         end
      end else if (jr_s) begin
         pc_sel   = SEL_JR;
         if_flush = 1'b1;
         id_flush = 1'b1;
         state_d  = ST_RECOVER;
      end else if (stall) begin
         pc_write = 1'b0;
         pc_sel   = SEL_SEQ;
      end else if ((state_q == ST_NORMAL) && (if_is_jump || predict_s)) begin
         // A jump seen in RECOVER is on the wrong path and is ignored
         pc_sel   = SEL_TGT;
         if_flush = 1'b1;
      end else begin
         pc_sel = SEL_SEQ;
      end
   end

   // Saturating evaluation counter next values
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolve_s && (branch_cnt_q != {CNT_W{1'b1}})) begin
         branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         branch_cnt_d = branch_cnt_q;
      end
      if (mispredict_s && (mispred_cnt_q != {CNT_W{1'b1}})) begin
         mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         mispred_cnt_d = mispred_cnt_q;
      end
   end

   // State, table and counter registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_NORMAL;
         branch_cnt_q  <= {CNT_W{1'b0}};
         mispred_cnt_q <= {CNT_W{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= CNT_RESET;
         end
      end else begin
         state_q       <= state_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispred_cnt_q;

endmodule
